// File: rtl/ct_f_spsram_128x144_ctrl.sv
// Front-end controller for a 128x144 single-port SRAM macro: zero-fill sweep,
// valid/ready request to active-low strobes, and an in-order read response FIFO.
module ct_f_spsram_128x144_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 144,
  parameter int RD_LAT     = 1,
  parameter int RSP_DEPTH  = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clr_req,
  output logic                  init_done,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int OW = $clog2(RSP_DEPTH + RD_LAT + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  typedef enum logic [1:0] {INIT, RUN, DRAIN} state_t;

  state_t                               state, state_nxt;
  logic [ADDR_WIDTH-1:0]                init_cnt;
  logic [RD_LAT:1]                      vld_pipe;
  logic [RSP_DEPTH-1:0][DATA_WIDTH-1:0] fifo_mem;
  logic [PW-1:0]                        wr_ptr, rd_ptr;
  logic [CW-1:0]                        fifo_cnt;
  logic [OW-1:0]                        outstanding;
  logic                                 accept, rd_acc, push, pop, pipe_busy;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reads still in the latency pipe already own a FIFO slot.
  always_comb begin
    outstanding = OW'(fifo_cnt);
    for (int i = 1; i <= RD_LAT; i++) outstanding = outstanding + OW'(vld_pipe[i]);
  end

  assign pipe_busy = |vld_pipe;
  assign req_rdy   = (state == RUN) && (req_wr || (outstanding < OW'(RSP_DEPTH)));
  assign accept    = req_vld & req_rdy;
  assign rd_acc    = accept & ~req_wr;
  assign push      = vld_pipe[RD_LAT];
  assign rsp_vld   = (fifo_cnt != '0);
  assign pop       = rsp_vld & rsp_rdy;
  assign rsp_rdata = rsp_vld ? fifo_mem[rd_ptr] : '0;
  assign init_done = (state == RUN);

  always_comb begin
    state_nxt = state;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    unique case (state)
      INIT: begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = init_cnt;
        if (init_cnt == '1) state_nxt = RUN;
      end
      RUN: begin
        if (accept) begin
          sram_cen = 1'b0;
          sram_a   = req_addr;
          if (req_wr) begin
            sram_gwen = 1'b0;
            sram_wen  = ~req_wmask;
            sram_d    = req_wdata;
          end
        end
        if (clr_req) state_nxt = DRAIN;
      end
      DRAIN: if (!pipe_busy && !rsp_vld) state_nxt = INIT;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= INIT;
      init_cnt <= '0;
      vld_pipe <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      state    <= state_nxt;
      // Wraps to zero on the last sweep address, so RUN always starts cleared.
      init_cnt <= (state == INIT) ? init_cnt + 1'b1 : '0;
      vld_pipe[1] <= rd_acc;
      for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      assert (!(push && !pop && fifo_cnt == CW'(RSP_DEPTH)));
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= sram_q;
  end

endmodule

// File: tb/tb_ct_f_spsram_128x144_ctrl.sv
// Directed bench for ct_f_spsram_128x144_ctrl with a behavioural 128x144 macro.
module tb_ct_f_spsram_128x144_ctrl;
  localparam int AW = 7;
  localparam int DW = 144;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          clr_req = 1'b0;
  logic          init_done;
  logic          req_vld = 1'b0;
  logic          req_rdy;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [DW-1:0] req_wmask = '0;
  logic          rsp_vld;
  logic          rsp_rdy = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] sram_a;
  logic          sram_cen;
  logic          sram_gwen;
  logic [DW-1:0] sram_wen;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q = '0;

  logic [DW-1:0] mem [0:127];
  int n_cmp = 0;
  int n_err = 0;

  ct_f_spsram_128x144_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(1), .RSP_DEPTH(3)) dut (
    .CLK(CLK), .RST(RST), .clr_req(clr_req), .init_done(init_done),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
    .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
  );

  always #5 CLK = ~CLK;

  // Macro model: bit-masked write, registered read data one cycle later.
  always @(posedge CLK) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= mem[sram_a];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] dpat(input int a);
    return {9{8'(a), 8'h3C}};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expects to be entered in the cycle that drives sweep address 0.
  task automatic run_sweep(input string tag, input int clr_at);
    int bad = 0;
    for (int k = 0; k < 128; k++) begin
      if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== '0 || sram_d !== '0 ||
          sram_a !== AW'(k) || init_done !== 1'b0 || req_rdy !== 1'b0 || rsp_vld !== 1'b0) bad++;
      if (k == clr_at) clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
    end
    chk({tag, "_bad_cycles"}, DW'(bad), '0);
    #1;
    chk({tag, "_init_done"}, DW'(init_done), DW'(1));
    chk({tag, "_req_rdy"}, DW'(req_rdy), DW'(1));
    chk({tag, "_idle_cen"}, DW'(sram_cen), DW'(1));
  endtask

  task automatic do_write(input string tag, input int addr, input logic [DW-1:0] data,
                          input logic [DW-1:0] mask);
    req_vld = 1'b1; req_wr = 1'b1; req_addr = AW'(addr); req_wdata = data; req_wmask = mask;
    #1;
    chk({tag, "_rdy"}, DW'(req_rdy), DW'(1));
    chk({tag, "_pins"}, DW'({sram_cen, sram_gwen, sram_a}), DW'({1'b0, 1'b0, AW'(addr)}));
    chk({tag, "_wen"}, sram_wen, ~mask);
    chk({tag, "_d"}, sram_d, data);
    tick();
    req_vld = 1'b0; req_wr = 1'b0;
  endtask

  task automatic do_read(input string tag, input int addr, input logic [DW-1:0] exp);
    rsp_rdy = 1'b1;
    req_vld = 1'b1; req_wr = 1'b0; req_addr = AW'(addr);
    #1;
    chk({tag, "_rdy"}, DW'(req_rdy), DW'(1));
    chk({tag, "_pins"}, DW'({sram_cen, sram_gwen, sram_a}), DW'({1'b0, 1'b1, AW'(addr)}));
    chk({tag, "_wen"}, sram_wen, '1);
    tick();
    req_vld = 1'b0;
    #1;
    chk({tag, "_vld_c1"}, DW'(rsp_vld), '0);
    tick();
    chk({tag, "_vld_c2"}, DW'(rsp_vld), DW'(1));
    chk({tag, "_data"}, rsp_rdata, exp);
    tick();
    chk({tag, "_popped"}, DW'(rsp_vld), '0);
  endtask

  initial begin
    int acc, issued, got, cyc, bad, w;
    logic [DW-1:0] expq [$];
    for (int i = 0; i < 128; i++)
      mem[i] = {16'hDEAD, $urandom, $urandom, $urandom, $urandom};

    repeat (3) tick();
    chk("rst_init_done", DW'(init_done), '0);
    chk("rst_req_rdy", DW'(req_rdy), '0);
    chk("rst_rsp_vld", DW'(rsp_vld), '0);
    chk("rst_rsp_rdata", rsp_rdata, '0);
    RST = 1'b0;
    run_sweep("sweep1", -1);

    do_read("rd5_zero", 5, '0);
    do_write("wr3", 3, {18{8'hA5}}, '1);
    do_read("rd3", 3, {18{8'hA5}});
    do_write("wr3_part", 3, '1, DW'(8'hFF));
    do_read("rd3_part", 3, {{17{8'hA5}}, 8'hFF});
    do_write("wr3_nomask", 3, '0, '0);
    do_read("rd3_nomask", 3, {{17{8'hA5}}, 8'hFF});

    for (int a = 10; a < 14; a++) do_write("wr_blk", a, dpat(a), '1);

    // Backpressure: three reads fill pipe+FIFO, further reads stall, writes pass.
    rsp_rdy = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      req_vld = 1'b1; req_wr = 1'b0; req_addr = AW'(10 + acc);
      #1;
      if (req_rdy) acc++;
      tick();
    end
    chk("bp_accepts", DW'(acc), DW'(3));
    chk("bp_rd_blocked", DW'(req_rdy), '0);
    req_wr = 1'b1; req_addr = AW'(20); req_wdata = dpat(20); req_wmask = '1;
    #1;
    chk("bp_wr_rdy", DW'(req_rdy), DW'(1));
    tick();
    req_vld = 1'b0; req_wr = 1'b0;
    rsp_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rsp_vld", DW'(rsp_vld), DW'(1));
      chk("bp_rsp_data", rsp_rdata, dpat(10 + i));
      tick();
    end
    chk("bp_drained", DW'(rsp_vld), '0);
    chk("bp_rdy_back", DW'(req_rdy), DW'(1));
    do_read("rd20", 20, dpat(20));

    // Streaming reads with rsp_rdy held high: one per cycle, in order.
    issued = 0; got = 0; cyc = 0;
    rsp_rdy = 1'b1;
    while (got < 10 && cyc < 40) begin
      if (issued < 10) begin
        req_vld = 1'b1; req_wr = 1'b0; req_addr = AW'(10 + issued % 4);
      end else req_vld = 1'b0;
      #1;
      if (req_vld && req_rdy) begin
        expq.push_back(dpat(10 + issued % 4));
        issued++;
      end
      if (rsp_vld) begin
        if (expq.size() == 0) chk("thru_unexpected", DW'(rsp_vld), '0);
        else chk("thru_data", rsp_rdata, expq.pop_front());
        got++;
      end
      tick();
      cyc++;
    end
    req_vld = 1'b0;
    chk("thru_got", DW'(got), DW'(10));
    chk("thru_cycles", DW'(cyc), DW'(12));

    // Clear with two reads pending; clr_req coincides with the second accept.
    do_write("wr40", 40, dpat(40), '1);
    rsp_rdy = 1'b0;
    req_vld = 1'b1; req_wr = 1'b0; req_addr = AW'(10);
    tick();
    req_addr = AW'(11); clr_req = 1'b1;
    #1;
    chk("clr_acc_rdy", DW'(req_rdy), DW'(1));
    tick();
    clr_req = 1'b0; req_vld = 1'b0;
    #1;
    chk("drain_init_done", DW'(init_done), '0);
    chk("drain_req_rdy", DW'(req_rdy), '0);
    repeat (4) tick();
    chk("drain_hold", DW'({init_done, rsp_vld, sram_cen}), DW'(3'b011));
    rsp_rdy = 1'b1;
    #1;
    chk("drain_rsp0", rsp_rdata, dpat(10));
    tick();
    chk("drain_rsp1", rsp_rdata, dpat(11));
    tick();
    rsp_rdy = 1'b0;
    w = 0;
    while (sram_cen !== 1'b0 && w < 10) begin
      tick();
      w++;
    end
    chk("drain_to_init", DW'(sram_cen), '0);
    run_sweep("sweep2", 50);
    do_read("rd40_clr", 40, '0);
    do_read("rd3_clr", 3, '0);

    // Reset with a read in flight: it must never reach the FIFO.
    do_write("wr7", 7, dpat(7), '1);
    rsp_rdy = 1'b1;
    req_vld = 1'b1; req_wr = 1'b0; req_addr = AW'(7);
    tick();
    req_vld = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_inflight_vld", DW'(rsp_vld), '0);
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      if (rsp_vld !== 1'b0 || sram_a !== AW'(k)) bad++;
      tick();
    end
    chk("rst_partial_sweep", DW'(bad), '0);
    chk("rst_at_60", DW'(sram_a), DW'(60));
    RST = 1'b1;
    tick();
    RST = 1'b0;
    run_sweep("sweep3", -1);
    do_read("rd7_rst", 7, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ct_f_spsram_128x144_ctrl.md
Name: ct_f_spsram_128x144_ctrl

Overview:
Front-end controller that directly drives one 128x144 single-port FPGA SRAM macro, the next stage downstream of the requesters and upstream of the macro pins (A/CEN/GWEN/WEN/D/Q). After reset it zero-fills the whole array. It then converts a valid/ready request stream into active-low macro strobes and returns read data through a small response FIFO with backpressure. A software clear request re-runs the zero-fill once in-flight reads have drained.

Parameters:
- ADDR_WIDTH, 7, macro address width (depth = 2**ADDR_WIDTH = 128).
- DATA_WIDTH, 144, data width.
- RD_LAT, 1, cycles from the macro access cycle (CEN=0) to sram_q being valid.
- RSP_DEPTH, 3, response FIFO entries. Must be >= RD_LAT+1.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- clr_req  in  1  single-cycle pulse that requests a re-zero of the array.
- init_done  out  1  array initialised; controller in RUN state.
- req_vld  in  1  request valid.
- req_rdy  out  1  request accepted when req_vld & req_rdy.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  access address.
- req_wdata  in  DATA_WIDTH  write data.
- req_wmask  in  DATA_WIDTH  write bit-enable, active-high.
- rsp_vld  out  1  read data valid (FIFO head).
- rsp_rdy  in  1  read data consumed when rsp_vld & rsp_rdy.
- rsp_rdata  out  DATA_WIDTH  read data.
- sram_a  out  ADDR_WIDTH  macro address.
- sram_cen  out  1  macro chip enable, active-low.
- sram_gwen  out  1  macro global write enable, active-low.
- sram_wen  out  DATA_WIDTH  macro bit write enable, active-low.
- sram_d  out  DATA_WIDTH  macro write data.
- sram_q  in  DATA_WIDTH  macro read data.

Behaviour:
- States: INIT, RUN, DRAIN.
- Reset: state=INIT, init counter=0, FIFO empty, in-flight pipe cleared. Outputs: init_done=0, req_rdy=0, rsp_vld=0, rsp_rdata=0. Read data in flight at reset is discarded. Reset asserted mid-sweep restarts the sweep at address 0.
- INIT: each cycle drives sram_cen=0, sram_gwen=0, sram_wen=all 0, sram_d=0, sram_a=counter, then counter increments. Write to address 127 → next state RUN, counter cleared. The sweep takes exactly 128 cycles.
- RUN:
  - init_done=1.
  - Write: req_rdy = 1.
  - Read: req_rdy = (outstanding < RSP_DEPTH), where outstanding = reads in the latency pipe + FIFO occupancy. No same-cycle pop bypass.
  - Macro pins are combinational from the accepted request. Accepted write: cen=0, gwen=0, wen=~req_wmask, d=req_wdata, a=req_addr. Accepted read: cen=0, gwen=1, wen=all 1.
  - No accept: cen=1, gwen=1, wen=all 1, a=0, d=0.
- Read pipe: a valid bit shifts RD_LAT stages. When the bit exits, sram_q is pushed into the FIFO on that clock edge. rsp_vld is therefore asserted RD_LAT+1 cycles after the accept edge, i.e. 2 cycles by default. The pipe has no backpressure; overflow is impossible by construction of req_rdy.
- FIFO: in order; push and pop can occur in the same cycle; rsp_rdata = head entry. Occupancy is never > RSP_DEPTH (assertion).
- Ordering: requests are served strictly in order. A read of an address written in an earlier cycle returns the new data.
- req_wmask = 0: access issued with gwen=0 and wen all 1; no bits change.
- clr_req in RUN → DRAIN. clr_req in INIT or DRAIN is ignored.
- DRAIN: req_rdy=0 and init_done=0. The FIFO still drains via rsp_rdy. When the pipe is empty and FIFO occupancy=0 → INIT.
- A clr_req arriving in the same cycle as an accepted request: the request completes normally, then the state moves to DRAIN.

Test Plan:
- Reset then idle: sram_cen=0 for exactly 128 cycles with sram_a = 0..127, wen=0, d=0. init_done and req_rdy rise in cycle 128. Reading addr 5 → rsp_rdata=0.
- Write addr 3, data 0x…A5, mask all ones; then read addr 3 → rsp_vld 2 cycles after the read accept, rsp_rdata = 0x…A5. Partial mask (low 8 bits) over 0x…FF data → only bits [7:0] updated.
- Back-to-back reads with rsp_rdy=0 → exactly 3 reads accepted, then req_rdy=0 for reads while a write is still accepted. Raise rsp_rdy → data returned in order, req_rdy re-rises.
- Read throughput with rsp_rdy=1 continuously: 10 reads complete with no FIFO overflow and in-order data.
- clr_req with 2 reads pending and rsp_rdy=0: stays in DRAIN (init_done=0). Once both responses pop, a 128-cycle sweep runs and earlier written data reads back 0.
- RST asserted at sweep address 60 and during an in-flight read: sweep restarts at 0, rsp_vld=0, and the stale read never appears.
